// File: rtl/l2_bus_arbiter_pkg.sv
// Shared types for the L2 bus arbiter: FSM state encoding, core-id width
// and the request bundle carried from an L1 miss port to L2.
package l2_bus_arbiter_pkg;

    localparam int CORE_ID_W  = 2;
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  wr;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/l2_bus_arbiter_if.sv
// Bus bundle between two L1 miss ports, the shared L2 port and the snoop broadcast.
// Handshake: cN_req_valid is level-held until the matching one-cycle cN_resp_valid; all other valids are single-cycle pulses.
interface l2_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CORE_ID_W  = 2
) ();
    logic                  c0_req_valid;
    logic                  c0_req_wr;
    logic [ADDR_WIDTH-1:0] c0_req_addr;
    logic [DATA_WIDTH-1:0] c0_req_wdata;
    logic                  c0_resp_valid;
    logic [DATA_WIDTH-1:0] c0_resp_rdata;

    logic                  c1_req_valid;
    logic                  c1_req_wr;
    logic [ADDR_WIDTH-1:0] c1_req_addr;
    logic [DATA_WIDTH-1:0] c1_req_wdata;
    logic                  c1_resp_valid;
    logic [DATA_WIDTH-1:0] c1_resp_rdata;

    logic                  l2_req_valid;
    logic                  l2_req_wr;
    logic [ADDR_WIDTH-1:0] l2_req_addr;
    logic [DATA_WIDTH-1:0] l2_req_wdata;
    logic                  l2_resp_valid;
    logic [DATA_WIDTH-1:0] l2_resp_rdata;

    logic                  snoop_valid;
    logic [ADDR_WIDTH-1:0] snoop_addr;
    logic [CORE_ID_W-1:0]  snoop_source_id;
    logic                  err_timeout;

    // master: the arbiter itself (it masters the L2 port)
    modport master (
        input  c0_req_valid, c0_req_wr, c0_req_addr, c0_req_wdata,
        output c0_resp_valid, c0_resp_rdata,
        input  c1_req_valid, c1_req_wr, c1_req_addr, c1_req_wdata,
        output c1_resp_valid, c1_resp_rdata,
        output l2_req_valid, l2_req_wr, l2_req_addr, l2_req_wdata,
        input  l2_resp_valid, l2_resp_rdata,
        output snoop_valid, snoop_addr, snoop_source_id, err_timeout
    );

    modport slave (
        output c0_req_valid, c0_req_wr, c0_req_addr, c0_req_wdata,
        input  c0_resp_valid, c0_resp_rdata,
        output c1_req_valid, c1_req_wr, c1_req_addr, c1_req_wdata,
        input  c1_resp_valid, c1_resp_rdata,
        input  l2_req_valid, l2_req_wr, l2_req_addr, l2_req_wdata,
        output l2_resp_valid, l2_resp_rdata,
        input  snoop_valid, snoop_addr, snoop_source_id, err_timeout
    );
endinterface

// File: rtl/l2_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie
// i_rr_ptr picks the winner (0 -> core0). Purely combinational.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_rr_ptr,
    output logic [1:0] o_grant
);
    assign o_grant[0] = i_req[0] & (~i_req[1] | ~i_rr_ptr);
    assign o_grant[1] = i_req[1] & (~i_req[0] |  i_rr_ptr);
endmodule

// File: rtl/l2_bus_arbiter.sv
// Shares one L2 request port between two L1 miss interfaces, one transaction
// in flight, with write snoop broadcast and a sticky lost-response flag.
module l2_bus_arbiter
    import l2_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = BUS_ADDR_W,
    parameter int DATA_WIDTH     = BUS_DATA_W,
    parameter int CORE_ID_W      = l2_bus_arbiter_pkg::CORE_ID_W,
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit SNOOP_ON_READ  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    l2_bus_arbiter_if.master        bus,
    output arb_state_t              o_state
);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t            r_state, w_state_nxt;
    logic                  w_grant_fire, w_resp_fire, w_timeout;
    logic [1:0]            w_req, w_grant;
    logic                  w_sel_core, w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata, w_resp_data;

    logic                  r_rr_ptr, r_owner, r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_l2_req_valid, r_snoop_valid, r_err;
    logic                  r_c0_resp_valid, r_c1_resp_valid;
    logic [DATA_WIDTH-1:0] r_c0_rdata, r_c1_rdata;

    assign w_req = {bus.c1_req_valid, bus.c0_req_valid};

    rr_arbiter2 u_rr (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant)
    );

    assign w_sel_core  = w_grant[1];
    assign w_sel_wr    = w_sel_core ? bus.c1_req_wr    : bus.c0_req_wr;
    assign w_sel_addr  = w_sel_core ? bus.c1_req_addr  : bus.c0_req_addr;
    assign w_sel_wdata = w_sel_core ? bus.c1_req_wdata : bus.c0_req_wdata;
    assign w_resp_data = w_timeout ? '0 : bus.l2_resp_rdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        w_resp_fire  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the last allowed cycle still wins over the timeout.
                if (bus.l2_resp_valid) begin
                    w_resp_fire = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_resp_fire = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr        <= 1'b0;
            r_owner         <= 1'b0;
            r_wr            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_cnt           <= '0;
            r_l2_req_valid  <= 1'b0;
            r_snoop_valid   <= 1'b0;
            r_err           <= 1'b0;
            r_c0_resp_valid <= 1'b0;
            r_c1_resp_valid <= 1'b0;
            r_c0_rdata      <= '0;
            r_c1_rdata      <= '0;
        end else begin
            r_l2_req_valid  <= w_grant_fire;
            r_snoop_valid   <= w_grant_fire & (w_sel_wr | SNOOP_ON_READ);
            r_c0_resp_valid <= w_resp_fire & ~r_owner;
            r_c1_resp_valid <= w_resp_fire &  r_owner;

            if (w_grant_fire) begin
                r_owner <= w_sel_core;
                r_wr    <= w_sel_wr;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_cnt   <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Only the owner's read-data register moves; the other keeps its last value.
            if (w_resp_fire) begin
                if (r_owner) r_c1_rdata <= w_resp_data;
                else         r_c0_rdata <= w_resp_data;
                r_rr_ptr <= ~r_owner;
                if (w_timeout) r_err <= 1'b1;
            end
        end
    end

    assign bus.l2_req_valid    = r_l2_req_valid;
    assign bus.l2_req_wr       = r_wr;
    assign bus.l2_req_addr     = r_addr;
    assign bus.l2_req_wdata    = r_wdata;
    assign bus.snoop_valid     = r_snoop_valid;
    assign bus.snoop_addr      = r_addr;
    assign bus.snoop_source_id = CORE_ID_W'(r_owner);
    assign bus.err_timeout     = r_err;
    assign bus.c0_resp_valid   = r_c0_resp_valid;
    assign bus.c0_resp_rdata   = r_c0_rdata;
    assign bus.c1_resp_valid   = r_c1_resp_valid;
    assign bus.c1_resp_rdata   = r_c1_rdata;
    assign o_state             = r_state;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: directed scenarios plus a randomized two-core
// traffic run checked against a transaction-level round-robin model.
module tb_l2_bus_arbiter;
    import l2_bus_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    arb_state_t dbg_state;
    int         checks;
    int         errors;

    l2_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CORE_ID_W(2)) bus ();

    l2_bus_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .CORE_ID_W      (2),
        .TIMEOUT_CYCLES (8),
        .SNOOP_ON_READ  (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        bus.c0_req_valid  = 1'b0;
        bus.c0_req_wr     = 1'b0;
        bus.c0_req_addr   = '0;
        bus.c0_req_wdata  = '0;
        bus.c1_req_valid  = 1'b0;
        bus.c1_req_wr     = 1'b0;
        bus.c1_req_addr   = '0;
        bus.c1_req_wdata  = '0;
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_rdata = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        checks++; if (bus.l2_req_valid !== 1'b0) begin errors++; $display("FAIL reset_l2_req_valid got %0b exp 0", bus.l2_req_valid); end
        checks++; if (bus.snoop_valid !== 1'b0) begin errors++; $display("FAIL reset_snoop_valid got %0b exp 0", bus.snoop_valid); end
        checks++; if (bus.c0_resp_valid !== 1'b0 || bus.c1_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b%0b exp 00", bus.c1_resp_valid, bus.c0_resp_valid); end
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", bus.err_timeout); end
        checks++; if (bus.l2_req_addr !== 32'h0 || bus.c0_resp_rdata !== 32'h0 || bus.snoop_source_id !== 2'd0) begin errors++; $display("FAIL reset_fields got addr %h rdata %h id %0d exp 0", bus.l2_req_addr, bus.c0_resp_rdata, bus.snoop_source_id); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.l2_req_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_no_grant got %0d pulses exp 0", pulses); end
    endtask

    task automatic test_core0_read();
        bus.c0_req_valid = 1'b1;
        bus.c0_req_wr    = 1'b0;
        bus.c0_req_addr  = 32'h100;
        bus.c0_req_wdata = 32'h0;
        @(negedge clk);
        checks++; if (bus.l2_req_valid !== 1'b1) begin errors++; $display("FAIL rd_l2_req_valid got %0b exp 1", bus.l2_req_valid); end
        checks++; if (bus.l2_req_wr !== 1'b0 || bus.l2_req_addr !== 32'h100) begin errors++; $display("FAIL rd_l2_fields got wr %0b addr %h exp wr 0 addr 100", bus.l2_req_wr, bus.l2_req_addr); end
        checks++; if (bus.snoop_valid !== 1'b0) begin errors++; $display("FAIL rd_no_snoop got %0b exp 0", bus.snoop_valid); end
        @(negedge clk);
        checks++; if (bus.l2_req_valid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse got %0b exp 0", bus.l2_req_valid); end
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_rdata = 32'hCAFE0001;
        @(negedge clk);
        bus.l2_resp_valid = 1'b0;
        checks++; if (bus.c0_resp_valid !== 1'b1 || bus.c0_resp_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL rd_c0_resp got v %0b d %h exp v 1 d cafe0001", bus.c0_resp_valid, bus.c0_resp_rdata); end
        checks++; if (bus.c1_resp_valid !== 1'b0) begin errors++; $display("FAIL rd_c1_quiet got %0b exp 0", bus.c1_resp_valid); end
        bus.c0_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.c0_resp_valid !== 1'b0) begin errors++; $display("FAIL rd_resp_one_cycle got %0b exp 0", bus.c0_resp_valid); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_core1_write();
        bus.c1_req_valid = 1'b1;
        bus.c1_req_wr    = 1'b1;
        bus.c1_req_addr  = 32'h200;
        bus.c1_req_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (bus.l2_req_valid !== 1'b1 || bus.l2_req_wr !== 1'b1) begin errors++; $display("FAIL wr_l2_req got v %0b wr %0b exp 1 1", bus.l2_req_valid, bus.l2_req_wr); end
        checks++; if (bus.l2_req_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata got %h exp 12345678", bus.l2_req_wdata); end
        checks++; if (bus.snoop_valid !== 1'b1 || bus.snoop_addr !== 32'h200 || bus.snoop_source_id !== 2'd1) begin errors++; $display("FAIL wr_snoop got v %0b a %h id %0d exp 1 200 1", bus.snoop_valid, bus.snoop_addr, bus.snoop_source_id); end
        @(negedge clk);
        checks++; if (bus.snoop_valid !== 1'b0) begin errors++; $display("FAIL wr_snoop_one_cycle got %0b exp 0", bus.snoop_valid); end
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        bus.l2_resp_valid = 1'b0;
        checks++; if (bus.c1_resp_valid !== 1'b1 || bus.c1_resp_rdata !== 32'h0BAD0BAD) begin errors++; $display("FAIL wr_c1_resp got v %0b d %h exp 1 0bad0bad", bus.c1_resp_valid, bus.c1_resp_rdata); end
        checks++; if (bus.c0_resp_valid !== 1'b0 || bus.c0_resp_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL wr_c0_hold got v %0b d %h exp 0 cafe0001", bus.c0_resp_valid, bus.c0_resp_rdata); end
        bus.c1_req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_both_fair();
        int n;
        pulse_reset();
        bus.c0_req_valid = 1'b1; bus.c0_req_wr = 1'b0; bus.c0_req_addr = 32'h1000; bus.c0_req_wdata = 32'h0;
        bus.c1_req_valid = 1'b1; bus.c1_req_wr = 1'b1; bus.c1_req_addr = 32'h2000; bus.c1_req_wdata = 32'h5A5A5A5A;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (bus.l2_req_valid !== 1'b1 && n < 12) begin
                @(negedge clk);
                n++;
            end
            if (bus.l2_req_valid !== 1'b1) begin
                checks++; errors++;
                $display("FAIL both_grant_wait got no grant in 12 cycles exp grant %0d", t);
            end else begin
                checks++; if (bus.snoop_source_id !== 2'(t % 2)) begin errors++; $display("FAIL both_owner got %0d exp %0d", bus.snoop_source_id, t % 2); end
                checks++; if (bus.l2_req_addr !== ((t % 2) ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL both_addr got %h exp %h", bus.l2_req_addr, (t % 2) ? 32'h2000 : 32'h1000); end
                @(negedge clk);
                bus.l2_resp_valid = 1'b1;
                bus.l2_resp_rdata = 32'hF000 + 32'(t);
                @(negedge clk);
                bus.l2_resp_valid = 1'b0;
                checks++; if ({bus.c1_resp_valid, bus.c0_resp_valid} !== ((t % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL both_resp got %b exp %b", {bus.c1_resp_valid, bus.c0_resp_valid}, (t % 2) ? 2'b10 : 2'b01); end
            end
        end
        bus.c0_req_valid = 1'b0;
        bus.c1_req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int early;
        bus.c0_req_valid = 1'b1; bus.c0_req_wr = 1'b0; bus.c0_req_addr = 32'h300;
        @(negedge clk);
        checks++; if (bus.l2_req_valid !== 1'b1 || bus.snoop_source_id !== 2'd0) begin errors++; $display("FAIL to_grant got v %0b id %0d exp 1 0", bus.l2_req_valid, bus.snoop_source_id); end
        early = 0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (bus.c0_resp_valid === 1'b1 || bus.err_timeout === 1'b1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early got %0d early cycles exp 0", early); end
        @(negedge clk);
        checks++; if (bus.c0_resp_valid !== 1'b1 || bus.c0_resp_rdata !== 32'h0) begin errors++; $display("FAIL to_resp got v %0b d %h exp 1 0", bus.c0_resp_valid, bus.c0_resp_rdata); end
        checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %0b exp 1", bus.err_timeout); end
        bus.c0_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.l2_resp_valid = 1'b0;
        early = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.c0_resp_valid === 1'b1 || bus.c1_resp_valid === 1'b1 || bus.l2_req_valid === 1'b1) early++;
            @(negedge clk);
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_late_resp got %0d active cycles exp 0", early); end
        checks++; if (bus.err_timeout !== 1'b1 || dbg_state !== IDLE) begin errors++; $display("FAIL to_sticky got err %0b st %0d exp 1 %0d", bus.err_timeout, dbg_state, IDLE); end
    endtask

    task automatic test_reset_in_wait();
        int stray;
        bus.c1_req_valid = 1'b1; bus.c1_req_wr = 1'b1; bus.c1_req_addr = 32'h400; bus.c1_req_wdata = 32'h44;
        @(negedge clk);
        checks++; if (bus.l2_req_valid !== 1'b1 || bus.snoop_source_id !== 2'd1) begin errors++; $display("FAIL rw_grant got v %0b id %0d exp 1 1", bus.l2_req_valid, bus.snoop_source_id); end
        @(negedge clk);
        rst = 1'b1;
        bus.c1_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.err_timeout !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL rw_cleared got err %0b st %0d exp 0 %0d", bus.err_timeout, dbg_state, IDLE); end
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_rdata = 32'h55;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.c0_resp_valid === 1'b1 || bus.c1_resp_valid === 1'b1) stray++;
            @(negedge clk);
            bus.l2_resp_valid = 1'b0;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rw_dropped_resp got %0d pulses exp 0", stray); end
        bus.c0_req_valid = 1'b1; bus.c0_req_wr = 1'b1; bus.c0_req_addr = 32'h500; bus.c0_req_wdata = 32'hA5A5A5A5;
        bus.c1_req_valid = 1'b1; bus.c1_req_wr = 1'b0; bus.c1_req_addr = 32'h600;
        @(negedge clk);
        checks++; if (bus.l2_req_valid !== 1'b1 || bus.snoop_source_id !== 2'd0) begin errors++; $display("FAIL rw_regrant got v %0b id %0d exp 1 0", bus.l2_req_valid, bus.snoop_source_id); end
        checks++; if (bus.l2_req_addr !== 32'h500 || bus.l2_req_wdata !== 32'hA5A5A5A5 || bus.l2_req_wr !== 1'b1) begin errors++; $display("FAIL rw_fresh got a %h d %h wr %0b exp 500 a5a5a5a5 1", bus.l2_req_addr, bus.l2_req_wdata, bus.l2_req_wr); end
        @(negedge clk);
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_rdata = 32'h77;
        @(negedge clk);
        bus.l2_resp_valid = 1'b0;
        checks++; if (bus.c0_resp_valid !== 1'b1) begin errors++; $display("FAIL rw_c0_resp got %0b exp 1", bus.c0_resp_valid); end
        bus.c0_req_valid = 1'b0;
        bus.c1_req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit          pend[2], prev_pend[2];
        logic        wr_f[2];
        logic [31:0] addr_f[2], wd_f[2];
        int          waited[2];
        int          last_owner, cur_owner, cd, ntx, w;
        bit          busy, exp_now, exp_next, e0, e1;
        logic [31:0] exp_data;
        clear_inputs();
        pulse_reset();
        pend = '{0, 0}; prev_pend = '{0, 0}; waited = '{0, 0};
        last_owner = 1; cur_owner = 0; cd = 0; ntx = 0;
        busy = 0; exp_next = 0; exp_data = '0;
        for (int cyc = 0; cyc < 380; cyc++) begin
            @(negedge clk);
            exp_now = exp_next;
            exp_next = 0;
            bus.l2_resp_valid = 1'b0;
            e0 = exp_now && cur_owner == 0;
            e1 = exp_now && cur_owner == 1;
            checks++; if (bus.c0_resp_valid !== e0) begin errors++; $display("FAIL rnd_c0_valid cyc %0d got %0b exp %0b", cyc, bus.c0_resp_valid, e0); end
            checks++; if (bus.c1_resp_valid !== e1) begin errors++; $display("FAIL rnd_c1_valid cyc %0d got %0b exp %0b", cyc, bus.c1_resp_valid, e1); end
            if (e0) begin checks++; if (bus.c0_resp_rdata !== exp_data) begin errors++; $display("FAIL rnd_c0_rdata got %h exp %h", bus.c0_resp_rdata, exp_data); end end
            if (e1) begin checks++; if (bus.c1_resp_rdata !== exp_data) begin errors++; $display("FAIL rnd_c1_rdata got %h exp %h", bus.c1_resp_rdata, exp_data); end end
            if (exp_now) begin
                pend[cur_owner] = 0;
                busy = 0;
            end
            if (bus.l2_req_valid === 1'b1) begin
                checks++; if (busy) begin errors++; $display("FAIL rnd_grant_busy cyc %0d got grant exp none", cyc); end
                if (!prev_pend[0] && !prev_pend[1]) begin
                    checks++; errors++;
                    $display("FAIL rnd_spurious cyc %0d got grant exp none", cyc);
                end else begin
                    w = (prev_pend[0] && prev_pend[1]) ? 1 - last_owner : (prev_pend[1] ? 1 : 0);
                    checks++; if (bus.snoop_source_id !== 2'(w)) begin errors++; $display("FAIL rnd_owner cyc %0d got %0d exp %0d", cyc, bus.snoop_source_id, w); end
                    checks++; if (bus.l2_req_addr !== addr_f[w] || bus.l2_req_wr !== wr_f[w] || bus.l2_req_wdata !== wd_f[w]) begin errors++; $display("FAIL rnd_fields got %h %0b %h exp %h %0b %h", bus.l2_req_addr, bus.l2_req_wr, bus.l2_req_wdata, addr_f[w], wr_f[w], wd_f[w]); end
                    checks++; if (bus.snoop_valid !== wr_f[w] || bus.snoop_addr !== addr_f[w]) begin errors++; $display("FAIL rnd_snoop got %0b %h exp %0b %h", bus.snoop_valid, bus.snoop_addr, wr_f[w], addr_f[w]); end
                    if (prev_pend[1 - w]) begin
                        waited[1 - w]++;
                        checks++; if (waited[1 - w] > 1) begin errors++; $display("FAIL rnd_starve core %0d got %0d foreign grants exp <=1", 1 - w, waited[1 - w]); end
                    end
                    waited[w] = 0;
                    last_owner = w;
                    cur_owner = w;
                    busy = 1;
                    cd = $urandom_range(1, 4);
                    ntx++;
                end
            end else if (busy && cd > 0) begin
                cd--;
                if (cd == 0) begin
                    exp_data = $urandom;
                    bus.l2_resp_valid = 1'b1;
                    bus.l2_resp_rdata = exp_data;
                    exp_next = 1;
                end
            end
            if (cyc < 340) begin
                for (int c = 0; c < 2; c++) begin
                    if (!pend[c] && $urandom_range(0, 3) == 0) begin
                        pend[c]   = 1;
                        wr_f[c]   = 1'($urandom_range(0, 1));
                        addr_f[c] = $urandom;
                        wd_f[c]   = $urandom;
                    end
                end
            end
            bus.c0_req_valid = pend[0]; bus.c0_req_wr = wr_f[0]; bus.c0_req_addr = addr_f[0]; bus.c0_req_wdata = wd_f[0];
            bus.c1_req_valid = pend[1]; bus.c1_req_wr = wr_f[1]; bus.c1_req_addr = addr_f[1]; bus.c1_req_wdata = wd_f[1];
            prev_pend = pend;
        end
        checks++; if (pend[0] || pend[1] || busy) begin errors++; $display("FAIL rnd_drain got pend %0b%0b busy %0b exp 000", pend[1], pend[0], busy); end
        checks++; if (ntx < 20) begin errors++; $display("FAIL rnd_traffic got %0d transactions exp >=20", ntx); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clear_inputs();
        wr_init();
        test_reset();
        test_core0_read();
        test_core1_write();
        test_both_fair();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic wr_init();
        @(negedge clk);
    endtask

endmodule
